simmem_axi_responder: RTL
=========================

SIMMEM_AXI_RESPONDER -- requirements
Module: simmem_axi_responder

Interface
REQ-001 SHALL have parameter RDataBase, default 4'h0, offset added into generated read data.
REQ-002 SHALL have ports: clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have: rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have: waddr_i input waddr_t, waddr_in_valid_i input 1, waddr_in_ready_o output 1 (AW channel).
REQ-005 SHALL have: wdata_i input wdata_t, wdata_in_valid_i input 1, wdata_in_ready_o output 1 (W channel).
REQ-006 SHALL have: wrsp_o output wrsp_t, wrsp_out_valid_o output 1, wrsp_out_ready_i input 1 (B channel).
REQ-007 SHALL have: raddr_i input raddr_t, raddr_in_valid_i input 1, raddr_in_ready_o output 1 (AR channel).
REQ-008 SHALL have: rdata_o output rdata_t, rdata_out_valid_o output 1, rdata_out_ready_i input 1 (R channel).

Function
REQ-009 SHALL act as the memory-side AXI responder: one outstanding write and one outstanding read, independent, concurrent.
REQ-010 Handshake on any channel SHALL occur on a cycle with valid and ready both high; valid outputs SHALL hold, with payload stable, until accepted.
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RSP; ready/valid driven only from state (no combinational input-to-output path).
REQ-012 W_IDLE: waddr_in_ready_o=1; on AW handshake latch id and burst_len, clear beat counter, go W_DATA next cycle.
REQ-013 W_DATA: wdata_in_ready_o=1; each W handshake increments 8-bit beat counter; handshake of beat number burst_len+1 moves to W_RSP.
REQ-014 W_RSP: wrsp_out_valid_o=1, wrsp_o.id=latched id, payload=OKAY (3'd0) unless REQ-023; on B handshake return to W_IDLE.
REQ-015 Read FSM SHALL have states R_IDLE, R_DATA; R_IDLE: raddr_in_ready_o=1; on AR handshake latch id, addr, burst_len, clear counter, go R_DATA.
REQ-016 R_DATA: rdata_out_valid_o=1; emit burst_len+1 beats; data = addr[3:0] + beat_index + RDataBase, modulo 2^4; response=0; id=latched id.
REQ-017 rdata last SHALL be 1 only on beat index burst_len; handshake of that beat returns to R_IDLE.
REQ-018 burst_len=0 SHALL yield exactly one beat with last=1; burst_len=255 SHALL yield 256 beats with no counter wrap before the final beat.
REQ-019 Minimum AW-to-B latency SHALL be burst_len+3 cycles (AW, beats, B); AR handshake to first R valid SHALL be 1 cycle.
REQ-020 AW and AR handshakes in the same cycle SHALL both be accepted; a stalled B or R output SHALL not block the other direction.
REQ-021 All outputs not asserted by current state SHALL be 0 (ready/valid) and payloads SHALL be 0 outside W_RSP/R_DATA.

Reset
REQ-022 rst_i high at a clock edge SHALL put both FSMs in idle, clear counters, latches and error flag; waddr_in_ready_o=1, raddr_in_ready_o=1, all other outputs 0 next cycle; in-flight bursts, including mid-burst, SHALL be dropped without response.

Configuration
REQ-023 With SIMMEM_RESPONDER_LAST_CHECK_EN defined: error flag set if wdata last=1 on any non-final beat or 0 on final beat; B payload=SLVERR (3'd2) if flag set; flag cleared on B handshake.
REQ-024 Without SIMMEM_RESPONDER_LAST_CHECK_EN: wdata last ignored, B payload always OKAY; beat count alone ends the burst.

Structure
REQ-025 State enums (w_state_e, r_state_e) and OKAY/SLVERR response constants SHALL live in simmem_pkg; channel types reused from simmem_pkg unchanged.
REQ-026 Sub-module simmem_axi_responder_rd SHALL hold the read FSM; write FSM SHALL stay in the top module.

Verification
REQ-027 AW id=2 burst_len=3, four W beats last on 4th, B ready=1 -> B valid exactly once, id=2, payload 0, AW-to-B = 6 cycles.
REQ-028 AR id=1 addr=0x0000E burst_len=2, RDataBase=0 -> R beats data 0xE,0xF,0x0, last only on 3rd, id=1.
REQ-029 R ready held low 5 cycles mid-burst -> beat payload stable, no beat lost or duplicated; concurrent write completes meanwhile.
REQ-030 Macro defined, burst_len=1, last=1 on beat 1 -> B payload 2; macro undefined, same stimulus -> payload 0.
REQ-031 rst_i pulsed during W_DATA after 2 of 4 beats -> no B emitted, waddr_in_ready_o=1 next cycle, next AW burst_len=0 completes normally.
REQ-032 AR burst_len=255 -> exactly 256 R beats, last on 256th only.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared channel payload types, response codes and FSM state enums for the
// simulated-memory AXI responder.
package simmem_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [19:0] addr;
      logic [7:0]  burst_len;
   } waddr_t;

   typedef struct packed {
      logic [3:0] data;
      logic       last;
   } wdata_t;

   typedef struct packed {
      logic [3:0] id;
      logic [2:0] rsp;
   } wrsp_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [19:0] addr;
      logic [7:0]  burst_len;
   } raddr_t;

   typedef struct packed {
      logic [3:0] id;
      logic [3:0] data;
      logic [2:0] rsp;
      logic       last;
   } rdata_t;

   localparam logic [2:0] RSP_OKAY   = 3'd0;
   localparam logic [2:0] RSP_SLVERR = 3'd2;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RSP  = 2'd2
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/simmem_axi_responder_rd.sv
// Read half of the simulated-memory responder: accepts one AR burst at a time
// and streams burst_len+1 generated beats on R.
module simmem_axi_responder_rd
   import simmem_pkg::*;
#(
   parameter logic [3:0] RDataBase = 4'h0
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  raddr_t raddr_i,
   input  logic   raddr_in_valid_i,
   output logic   raddr_in_ready_o,
   output rdata_t rdata_o,
   output logic   rdata_out_valid_o,
   input  logic   rdata_out_ready_i
);

   r_state_e   state_q;
   logic [3:0] id_q;
   logic [3:0] addr_q;
   logic [7:0] len_q;
   logic [7:0] beat_q;
   logic       is_last;
   logic       unused_raddr;

   assign is_last      = (beat_q == len_q);
   assign unused_raddr = ^raddr_i.addr[19:4];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= R_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         case (state_q)
            R_IDLE: begin
               if (raddr_in_valid_i) begin
                  id_q    <= raddr_i.id;
                  addr_q  <= raddr_i.addr[3:0];
                  len_q   <= raddr_i.burst_len;
                  beat_q  <= '0;
                  state_q <= R_DATA;
               end
            end
            R_DATA: begin
               // The counter stops at len_q, so a 256-beat burst never wraps.
               if (rdata_out_ready_i) begin
                  if (is_last) state_q <= R_IDLE;
                  else         beat_q  <= beat_q + 8'd1;
               end
            end
            default: state_q <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      raddr_in_ready_o  = (state_q == R_IDLE);
      rdata_out_valid_o = (state_q == R_DATA);
      rdata_o           = '0;
      if (state_q == R_DATA) begin
         rdata_o.id   = id_q;
         rdata_o.data = addr_q + beat_q[3:0] + RDataBase;
         rdata_o.rsp  = RSP_OKAY;
         rdata_o.last = is_last;
      end
   end

endmodule

// File: rtl/simmem_axi_responder.sv
// Memory-side AXI responder: one outstanding write (handled here) and one
// outstanding read (sub-module). SIMMEM_RESPONDER_LAST_CHECK_EN enables W last checking.
module simmem_axi_responder
   import simmem_pkg::*;
#(
   parameter logic [3:0] RDataBase = 4'h0
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  waddr_t waddr_i,
   input  logic   waddr_in_valid_i,
   output logic   waddr_in_ready_o,
   input  wdata_t wdata_i,
   input  logic   wdata_in_valid_i,
   output logic   wdata_in_ready_o,
   output wrsp_t  wrsp_o,
   output logic   wrsp_out_valid_o,
   input  logic   wrsp_out_ready_i,
   input  raddr_t raddr_i,
   input  logic   raddr_in_valid_i,
   output logic   raddr_in_ready_o,
   output rdata_t rdata_o,
   output logic   rdata_out_valid_o,
   input  logic   rdata_out_ready_i
);

   w_state_e   w_state_q;
   logic [3:0] w_id_q;
   logic [7:0] w_len_q;
   logic [7:0] w_beat_q;
   logic       w_final_beat;
   logic       w_err;
   logic       unused_wr;

   assign w_final_beat = (w_beat_q == w_len_q);
   assign unused_wr    = ^{waddr_i.addr, wdata_i};

`ifdef SIMMEM_RESPONDER_LAST_CHECK_EN
   logic w_err_q;

   // Sticky for the burst: any beat whose last flag disagrees with its position.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_err_q <= 1'b0;
      end else if (w_state_q == W_DATA && wdata_in_valid_i &&
                   (wdata_i.last != w_final_beat)) begin
         w_err_q <= 1'b1;
      end else if (w_state_q == W_RSP && wrsp_out_ready_i) begin
         w_err_q <= 1'b0;
      end
   end

   assign w_err = w_err_q;
`else
   assign w_err = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_beat_q  <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (waddr_in_valid_i) begin
                  w_id_q    <= waddr_i.id;
                  w_len_q   <= waddr_i.burst_len;
                  w_beat_q  <= '0;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (wdata_in_valid_i) begin
                  if (w_final_beat) w_state_q <= W_RSP;
                  else              w_beat_q  <= w_beat_q + 8'd1;
               end
            end
            W_RSP: begin
               if (wrsp_out_ready_i) w_state_q <= W_IDLE;
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      waddr_in_ready_o = (w_state_q == W_IDLE);
      wdata_in_ready_o = (w_state_q == W_DATA);
      wrsp_out_valid_o = (w_state_q == W_RSP);
      wrsp_o           = '0;
      if (w_state_q == W_RSP) begin
         wrsp_o.id  = w_id_q;
         wrsp_o.rsp = w_err ? RSP_SLVERR : RSP_OKAY;
      end
   end

   simmem_axi_responder_rd #(
      .RDataBase(RDataBase)
   ) u_rd (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .raddr_i           (raddr_i),
      .raddr_in_valid_i  (raddr_in_valid_i),
      .raddr_in_ready_o  (raddr_in_ready_o),
      .rdata_o           (rdata_o),
      .rdata_out_valid_o (rdata_out_valid_o),
      .rdata_out_ready_i (rdata_out_ready_i)
   );

endmodule
